bit_nibble_fifo_ctrl: RTL and testbench



---
 rtl/bit_nibble_fifo_ctrl_pkg.sv | 24 ++
 rtl/bit_nibble_fifo_ctrl_nibble_skid2.sv | 82 ++++++++
 rtl/bit_nibble_fifo_ctrl.sv | 109 ++++++++++
 tb/tb_bit_nibble_fifo_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_nibble_fifo_ctrl_pkg.sv
// ============================================================================
// Module   : bit_nibble_fifo_ctrl_pkg
// Brief    : Shared RAM geometry and output-buffer state encoding for the
//            bit-in / nibble-out FIFO controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_nibble_fifo_ctrl_pkg;

   localparam int BIT_AW     = 12;
   localparam int NIB_AW     = 10;
   localparam int DEPTH_BITS = 4096;
   localparam int FILL_W     = BIT_AW + 1;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/bit_nibble_fifo_ctrl_nibble_skid2.sv
// ============================================================================
// Module   : nibble_skid2
// Brief    : Two-entry register FIFO holding nibbles returned by RAM port B.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_skid2
   import bit_nibble_fifo_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic [3:0] data_i,
   input  logic       pop_i,
   output logic [3:0] data_o,
   output logic       valid_o,
   output logic       full_o,
   output logic [1:0] level_o
);

   skid_state_e state_q, state_d;
   logic [3:0]  head_q, head_d;
   logic [3:0]  tail_q, tail_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SKID_EMPTY;
         head_q  <= 4'd0;
         tail_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         SKID_EMPTY: begin
            if (push_i) begin
               state_d = SKID_ONE;
               head_d  = data_i;
            end
         end
         SKID_ONE: begin
            case ({push_i, pop_i})
               2'b10: begin
                  state_d = SKID_TWO;
                  tail_d  = data_i;
               end
               2'b01:   state_d = SKID_EMPTY;
               2'b11:   head_d  = data_i;
               default: state_d = SKID_ONE;
            endcase
         end
         SKID_TWO: begin
            // The issue rule in the parent guarantees no push arrives here.
            if (pop_i) begin
               state_d = SKID_ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
   end

   assign data_o  = head_q;
   assign valid_o = (state_q != SKID_EMPTY);
   assign full_o  = (state_q == SKID_TWO);
   assign level_o = (state_q == SKID_TWO) ? 2'd2 :
                    (state_q == SKID_ONE) ? 2'd1 : 2'd0;

   a_no_push_when_two: assert property (
      @(posedge clk_i) disable iff (rst_i) !(push_i && state_q == SKID_TWO));

endmodule

`default_nettype wire

// File: rtl/bit_nibble_fifo_ctrl.sv
// ============================================================================
// Module   : bit_nibble_fifo_ctrl
// Brief    : Drives a 4096x1 / 1024x4 dual-port RAM as a serial-bit-in,
//            nibble-out FIFO with a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_nibble_fifo_ctrl
   import bit_nibble_fifo_ctrl_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   input  logic                DIN,
   input  logic                DIN_VALID,
   output logic                DIN_READY,
   output logic [3:0]          DOUT,
   output logic                DOUT_VALID,
   input  logic                DOUT_READY,
   output logic [FILL_W-1:0]   FILL,
   output logic [BIT_AW-1:0]   ADDRA,
   output logic                DIA,
   output logic                ENA,
   output logic                WEA,
   output logic                RSTA,
   output logic [NIB_AW-1:0]   ADDRB,
   output logic [3:0]          DIB,
   output logic                WEB,
   output logic                RSTB,
   output logic                ENB,
   input  logic [3:0]          DOB
);

   logic [FILL_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [NIB_AW:0]   rd_ptr_q, rd_ptr_d;
   logic              inflight_q, inflight_d;

   logic [FILL_W-1:0] fill_w;
   logic              accept_w;
   logic              avail_w;
   logic              pop_w;
   logic              issue_w;
   logic [2:0]        occ_w;
   logic [1:0]        held_w;
   logic              skid_full_w;
   logic              skid_valid_w;
   logic [3:0]        skid_data_w;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         inflight_q <= inflight_d;
      end
   end

   // Fill counts only RAM-resident bits; issued nibbles have already left.
   assign fill_w   = wr_ptr_q - {rd_ptr_q, 2'b00};
   assign accept_w = DIN_VALID & DIN_READY;
   assign avail_w  = (fill_w >= FILL_W'(4));
   assign pop_w    = skid_valid_w & DOUT_READY;
   assign occ_w    = {1'b0, held_w} + {2'b00, inflight_q} - {2'b00, pop_w};
   assign issue_w  = avail_w & (occ_w < 3'd2);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      inflight_d = issue_w;
      if (accept_w) wr_ptr_d = wr_ptr_q + FILL_W'(1);
      if (issue_w)  rd_ptr_d = rd_ptr_q + (NIB_AW+1)'(1);
   end

   nibble_skid2 u_skid (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (inflight_q),
      .data_i  (DOB),
      .pop_i   (pop_w),
      .data_o  (skid_data_w),
      .valid_o (skid_valid_w),
      .full_o  (skid_full_w),
      .level_o (held_w)
   );

   a_no_issue_into_full: assert property (
      @(posedge CLK) disable iff (RST) !(skid_full_w && !pop_w && issue_w));

   assign DIN_READY  = (fill_w < FILL_W'(DEPTH_BITS));
   assign DOUT       = skid_data_w;
   assign DOUT_VALID = skid_valid_w;
   assign FILL       = fill_w;
   assign ADDRA      = wr_ptr_q[BIT_AW-1:0];
   assign DIA        = DIN;
   assign ENA        = accept_w;
   assign WEA        = accept_w;
   assign RSTA       = 1'b0;
   assign ADDRB      = rd_ptr_q[NIB_AW-1:0];
   assign DIB        = 4'd0;
   assign WEB        = 1'b0;
   assign RSTB       = 1'b0;
   assign ENB        = issue_w;

endmodule

`default_nettype wire

// File: tb/tb_bit_nibble_fifo_ctrl.sv
// ============================================================================
// Module   : tb_bit_nibble_fifo_ctrl
// Brief    : Directed and randomised bench for bit_nibble_fifo_ctrl with a
//            behavioural 4096x1 / 1024x4 dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_nibble_fifo_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        DIN;
   logic        DIN_VALID;
   logic        DOUT_READY;
   logic [3:0]  DOB;
   logic        DIN_READY;
   logic [3:0]  DOUT;
   logic        DOUT_VALID;
   logic [12:0] FILL;
   logic [11:0] ADDRA;
   logic        DIA, ENA, WEA, RSTA;
   logic [9:0]  ADDRB;
   logic [3:0]  DIB;
   logic        WEB, RSTB, ENB;

   bit_nibble_fifo_ctrl dut (
      .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
      .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .FILL(FILL),
      .ADDRA(ADDRA), .DIA(DIA), .ENA(ENA), .WEA(WEA), .RSTA(RSTA),
      .ADDRB(ADDRB), .DIB(DIB), .WEB(WEB), .RSTB(RSTB), .ENB(ENB), .DOB(DOB)
   );

   always #5 CLK = ~CLK;

   // Shared-array RAM: nibble n occupies bit addresses 4n..4n+3, LSB first.
   logic ram [0:4095];
   always @(posedge CLK) begin
      if (ENA && WEA) ram[ADDRA] <= DIA;
      if (ENB) DOB <= {ram[{ADDRB, 2'd3}], ram[{ADDRB, 2'd2}],
                       ram[{ADDRB, 2'd1}], ram[{ADDRB, 2'd0}]};
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   bit         refq[$];
   logic [3:0] popped[$];
   int         cyc, acc_cnt, acc4_cyc, first_v_cyc, first_enb_cyc;
   logic [9:0] first_enb_addr;
   logic       prev_stall;
   logic [3:0] prev_dout;
   logic       s_din_ready;

   // One clock: sample at the falling edge, then step past the rising edge.
   task automatic cycle();
      logic [3:0] exp;
      @(negedge CLK);
      if (prev_stall) check_eq("dout_stable", {27'd0, DOUT_VALID, DOUT}, {27'd0, 1'b1, prev_dout});
      prev_stall = DOUT_VALID && !DOUT_READY;
      prev_dout  = DOUT;
      if (DOUT_VALID && DOUT_READY) begin
         if (refq.size() >= 4) begin
            exp = {refq[3], refq[2], refq[1], refq[0]};
            repeat (4) void'(refq.pop_front());
            check_eq("pop_data", {28'd0, DOUT}, {28'd0, exp});
            popped.push_back(DOUT);
         end else begin
            check_eq("pop_underflow", refq.size(), 4);
         end
      end
      if (DIN_VALID && DIN_READY) begin
         refq.push_back(DIN);
         acc_cnt++;
         if (acc_cnt == 4 && acc4_cyc < 0) acc4_cyc = cyc;
      end
      if (DOUT_VALID && first_v_cyc < 0) first_v_cyc = cyc;
      if (ENB && first_enb_cyc < 0) begin
         first_enb_cyc  = cyc;
         first_enb_addr = ADDRB;
      end
      s_din_ready = DIN_READY;
      cyc++;
      @(posedge CLK);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         DIN       = bits[i];
         DIN_VALID = 1'b1;
         cycle();
      end
      DIN_VALID = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      refq.delete();
      popped.delete();
      prev_stall = 1'b0;
   endtask

   task automatic check_reset_outputs(input string sfx);
      check_eq({"rst_dout_", sfx},       {28'd0, DOUT}, 32'd0);
      check_eq({"rst_dout_valid_", sfx}, {31'd0, DOUT_VALID}, 32'd0);
      check_eq({"rst_fill_", sfx},       {19'd0, FILL}, 32'd0);
      check_eq({"rst_din_ready_", sfx},  {31'd0, DIN_READY}, 32'd1);
      check_eq({"rst_enb_", sfx},        {31'd0, ENB}, 32'd0);
      check_eq({"rst_ena_wea_", sfx},    {30'd0, ENA, WEA}, 32'd0);
      check_eq({"rst_addra_", sfx},      {20'd0, ADDRA}, 32'd0);
      check_eq({"rst_addrb_", sfx},      {22'd0, ADDRB}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      logic [3:0] nib;
      RST = 1'b1; DIN = 1'b0; DIN_VALID = 1'b0; DOUT_READY = 1'b0;
      prev_stall = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_reset_outputs("init");
      check_eq("tied_zero", {25'd0, RSTA, WEB, RSTB, DIB}, 32'd0);
      RST = 1'b0;

      // First nibbles and their latency
      cyc = 0; acc_cnt = 0; acc4_cyc = -1; first_v_cyc = -1; first_enb_cyc = -1;
      DOUT_READY = 1'b1;
      send_bits(32'h4D, 8);
      repeat (6) cycle();
      check_eq("t1_count", popped.size(), 2);
      if (popped.size() == 2) begin
         check_eq("t1_nib0", {28'd0, popped[0]}, 32'hD);
         check_eq("t1_nib1", {28'd0, popped[1]}, 32'h4);
      end
      check_eq("t1_enb_lat",  first_enb_cyc - acc4_cyc, 1);
      check_eq("t1_enb_addr", {22'd0, first_enb_addr}, 32'd0);
      check_eq("t1_valid_lat", first_v_cyc - acc4_cyc, 3);

      // Partial nibble is held back until complete
      popped.delete();
      send_bits(32'b011, 3);
      repeat (6) cycle();
      check_eq("t2_no_valid", {31'd0, DOUT_VALID}, 32'd0);
      check_eq("t2_fill3", {19'd0, FILL}, 32'd3);
      check_eq("t2_no_pop", popped.size(), 0);
      send_bits(32'b1, 1);
      repeat (6) cycle();
      check_eq("t2_count", popped.size(), 1);
      if (popped.size() == 1) begin
         nib = popped[0];
         check_eq("t2_nib", {28'd0, nib}, 32'hB);
         check_eq("t2_msb", {31'd0, nib[3]}, 32'd1);
      end

      // Fill to capacity with the consumer stalled
      DOUT_READY = 1'b0;
      DIN_VALID  = 1'b1;
      acc_cnt    = 0;
      for (int i = 0; i < 5000; i++) begin
         DIN = 1'($urandom);
         cycle();
         if (!s_din_ready) break;
      end
      DIN_VALID = 1'b0;
      check_eq("t3_accepted", acc_cnt, 4104);
      check_eq("t3_fill_full", {19'd0, FILL}, 32'd4096);
      check_eq("t3_din_ready_low", {31'd0, DIN_READY}, 32'd0);
      DOUT_READY = 1'b1;
      cycle();
      DOUT_READY = 1'b0;
      got = 0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         if (s_din_ready) begin
            got = 1;
            break;
         end
      end
      check_eq("t3_ready_back", got, 1);
      check_eq("t3_fill_after_pop", {19'd0, FILL}, 32'd4092);
      DOUT_READY = 1'b1;
      repeat (1100) cycle();
      check_eq("t3_drained_ref", refq.size(), 0);
      check_eq("t3_drained_fill", {19'd0, FILL}, 32'd0);
      check_eq("t3_drained_valid", {31'd0, DOUT_VALID}, 32'd0);

      // Random traffic across pointer wrap: a slow consumer phase, then a fast one
      popped.delete();
      acc_cnt = 0;
      for (int i = 0; i < 20000; i++) begin
         DIN        = 1'($urandom);
         DIN_VALID  = ($urandom_range(0, 3) != 0);
         DOUT_READY = (i < 10000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         cycle();
      end
      DIN_VALID  = 1'b0;
      DOUT_READY = 1'b1;
      repeat (1100) cycle();
      check_eq("t4_partial_fill", refq.size(), {19'd0, FILL});
      check_eq("t4_nibble_count", popped.size(), acc_cnt / 4);
      check_eq("t4_idle_valid", {31'd0, DOUT_VALID}, 32'd0);

      // Asynchronous reset with data in RAM, in flight and held
      do_reset();
      DOUT_READY = 1'b0;
      for (int i = 0; i < 49; i++) begin
         DIN       = 1'($urandom);
         DIN_VALID = 1'b1;
         cycle();
      end
      DIN_VALID = 1'b0;
      repeat (3) cycle();
      check_eq("t5_fill41", {19'd0, FILL}, 32'd41);
      check_eq("t5_valid", {31'd0, DOUT_VALID}, 32'd1);
      DOUT_READY = 1'b1;
      cycle();
      DOUT_READY = 1'b0;
      check_eq("t5_fill37", {19'd0, FILL}, 32'd37);
      prev_stall = 1'b0;
      RST = 1'b1;
      #1;
      check_reset_outputs("async");
      @(posedge CLK);
      #1;
      check_eq("t5_dob_ignored", {31'd0, DOUT_VALID}, 32'd0);
      RST = 1'b0;
      refq.delete();
      popped.delete();
      DOUT_READY = 1'b1;
      send_bits(32'b1110, 4);
      repeat (6) cycle();
      check_eq("t5_count", popped.size(), 1);
      if (popped.size() == 1) check_eq("t5_nib", {28'd0, popped[0]}, 32'hE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
